uart_rx_byte: RTL and testbench

- Serial UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Sits directly upstream of the RAM loader. Converts the board RXD pin into a parallel byte plus a one-cycle strobe (rxByte/newByte).
- Also feeds the UART peripheral RX path.
- Uses 16x oversampling with mid-bit sampling and rejects start-bit glitches.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_byte.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path (and the future transmitter).
package uart_pkg;

  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned MID_SAMPLE      = 7;
  localparam int unsigned DEFAULT_DIVISOR = 163;  // 50 MHz / (16 x 19200)
  localparam int unsigned DEFAULT_CNT_W   = 16;
  localparam int unsigned DATA_BITS       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample prescaler: one-cycle tick every DIVISOR HCLK cycles.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR   = DEFAULT_DIVISOR,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_W
) (
  input  logic HCLK,
  input  logic HRESETn,
  output logic tick
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;

  // tick is registered one count early so it is high exactly while cnt_q == DIVISOR-1
  always_comb begin
    cnt_d  = cnt_q + CNT_WIDTH'(1);
    tick_d = (cnt_q == CNT_WIDTH'(DIVISOR - 2));
    if (cnt_q == CNT_WIDTH'(DIVISOR - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, 16x oversampled with mid-bit sampling and start-glitch rejection.
// Define UART_RX_PARITY_EN to require an even-parity bit between data and stop.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR   = DEFAULT_DIVISOR,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_W
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       rxd,
  output logic [7:0] rxByte,
  output logic       newByte,
  output logic       frameErr,
  output logic       rxBusy
);

  logic                 tick;
  logic                 rx_meta_q, rxs_q;
  rx_state_e            state_q, state_d;
  logic [3:0]           sample_cnt_q, sample_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 new_byte_q, new_byte_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_busy_q, rx_busy_d;
  logic                 mid_tick, wrap_tick, frame_ok;
`ifdef UART_RX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_tick #(
    .DIVISOR   (DIVISOR),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_baud_tick (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .tick    (tick)
  );

  assign mid_tick  = tick && (sample_cnt_q == 4'(MID_SAMPLE));
  assign wrap_tick = tick && (sample_cnt_q == 4'(OVERSAMPLE - 1));
`ifdef UART_RX_PARITY_EN
  assign frame_ok  = ~(^{shift_q, parity_q});
`else
  assign frame_ok  = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    new_byte_d   = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d     = parity_q;
`endif
    if (tick) begin
      sample_cnt_d = sample_cnt_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d      = ST_START;
          sample_cnt_d = '0;
        end
      end
      ST_START: begin
        if (mid_tick) begin
          if (!rxs_q) begin
            state_d      = ST_DATA;
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (wrap_tick) begin
          shift_d[bit_cnt_q] = rxs_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (wrap_tick) begin
          parity_d = rxs_q;
          state_d  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (wrap_tick) begin
          // IDLE is re-entered at the stop midpoint so a back-to-back start bit is caught
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end else if (frame_ok) begin
            rx_byte_d  = shift_q;
            new_byte_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      new_byte_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rxd;
      rxs_q        <= rx_meta_q;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      new_byte_q   <= new_byte_d;
      frame_err_q  <= frame_err_d;
      rx_busy_q    <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign rxByte   = rx_byte_q;
  assign newByte  = new_byte_q;
  assign frameErr = frame_err_q;
  assign rxBusy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed and random frames against a frame-level reference model.
module tb_uart_rx_byte;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // strobe expected near the stop-bit midpoint on the pin, plus sync/register latency
  localparam int STROBE_OFS = (9 + PBITS) * BIT + BIT / 2;
  localparam int TOL_LO = 3;
  localparam int TOL_HI = 6;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rxByte;
  logic       newByte, frameErr, rxBusy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int nb_t[$];
  int nb_v[$];
  int fe_t[$];
  logic [7:0] exp_byte;

  uart_rx_byte #(
    .DIVISOR   (DIV),
    .CNT_WIDTH (16)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .rxd      (rxd),
    .rxByte   (rxByte),
    .newByte  (newByte),
    .frameErr (frameErr),
    .rxBusy   (rxBusy)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, want, want, cyc);
    end
  endtask

  // strobe recorder
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (newByte) begin
        nb_t.push_back(cyc);
        nb_v.push_back(int'(rxByte));
      end
      if (frameErr) fe_t.push_back(cyc);
      if (newByte || frameErr) check_eq("strobe_excl", int'(newByte && frameErr), 0);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    wait_cycles(BIT);
  endtask

  task automatic check_time(input string tag, input int dt);
    check_eq(tag, (dt >= STROBE_OFS - TOL_LO && dt <= STROBE_OFS + TOL_HI) ? STROBE_OFS : dt, STROBE_OFS);
  endtask

  // Sends start + 8 data (+ parity) + stop; a low stop bit holds the line low for low_bits more bits
  task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit par_good,
                            input int low_bits, output int strobe_t);
    int  t0;
    bit  good;
    t0 = cyc;
    strobe_t = -1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) check_eq("busy_mid", int'(rxBusy), 1);
      drive_bit(d[i]);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit(par_good ? ^d : ~^d);
    good = stop_v && par_good;
`else
    good = stop_v;
`endif
    drive_bit(stop_v);
    if (!stop_v) begin
      wait_cycles(low_bits * BIT);
      check_eq("break_quiet", nb_t.size() + fe_t.size(), 1);
      drive_bit(1'b1);
    end
    if (good) begin
      check_eq("nb_count", nb_t.size(), 1);
      check_eq("fe_count", fe_t.size(), 0);
      if (nb_t.size() > 0) begin
        check_eq("nb_value", nb_v[0], int'(d));
        check_time("nb_time", nb_t[0] - t0);
        strobe_t = nb_t[0];
      end
      exp_byte = d;
    end else begin
      check_eq("nb_count_bad", nb_t.size(), 0);
      check_eq("fe_count_bad", fe_t.size(), 1);
      if (fe_t.size() > 0) check_time("fe_time", fe_t[0] - t0);
    end
    check_eq("rxbyte_hold", int'(rxByte), int'(exp_byte));
    check_eq("busy_end", int'(rxBusy), 0);
    nb_t.delete();
    nb_v.delete();
    fe_t.delete();
  endtask

  task automatic glitch(input int len);
    rxd = 1'b0;
    wait_cycles(6);
    check_eq("glitch_busy", int'(rxBusy), 1);
    wait_cycles(len - 6);
    rxd = 1'b1;
    wait_cycles(BIT + 16);
    check_eq("glitch_busy_end", int'(rxBusy), 0);
    check_eq("glitch_strobes", nb_t.size() + fe_t.size(), 0);
    check_eq("glitch_rxbyte", int'(rxByte), int'(exp_byte));
    nb_t.delete();
    nb_v.delete();
    fe_t.delete();
  endtask

  initial begin
    int t_a, t_b;
    logic [7:0] d;
    int kind;
    exp_byte = 8'h00;
    wait_cycles(3);
    check_eq("rst_rxbyte", int'(rxByte), 0);
    check_eq("rst_newbyte", int'(newByte), 0);
    check_eq("rst_frameerr", int'(frameErr), 0);
    check_eq("rst_busy", int'(rxBusy), 0);
    HRESETn = 1'b1;
    wait_cycles(BIT);

    send_frame(8'h3A, 1'b1, 1'b1, 0, t_a);
    wait_cycles(BIT);
    glitch(20);
    send_frame(8'h55, 1'b0, 1'b1, 5, t_a);
    wait_cycles(BIT);
    send_frame(8'h0A, 1'b1, 1'b1, 0, t_a);

    // back-to-back frames with exactly one stop bit
    send_frame(8'h51, 1'b1, 1'b1, 0, t_a);
    send_frame(8'h0D, 1'b1, 1'b1, 0, t_b);
    if (t_a >= 0 && t_b >= 0) begin
      check_eq("b2b_spacing", (t_b - t_a >= BIT * (10 + PBITS) - 2 && t_b - t_a <= BIT * (10 + PBITS) + 2)
                              ? BIT * (10 + PBITS) : t_b - t_a, BIT * (10 + PBITS));
    end
    wait_cycles(BIT);

    // reset in the middle of a 0xFF frame
    rxd = 1'b0;
    wait_cycles(BIT);
    rxd = 1'b1;
    wait_cycles(3 * BIT);
    HRESETn = 1'b0;
    wait_cycles(4);
    check_eq("midrst_rxbyte", int'(rxByte), 0);
    check_eq("midrst_newbyte", int'(newByte), 0);
    check_eq("midrst_frameerr", int'(frameErr), 0);
    check_eq("midrst_busy", int'(rxBusy), 0);
    HRESETn = 1'b1;
    exp_byte = 8'h00;
    wait_cycles(8 * BIT);
    check_eq("midrst_no_strobe", nb_t.size() + fe_t.size(), 0);
    nb_t.delete();
    nb_v.delete();
    fe_t.delete();
    send_frame(8'h41, 1'b1, 1'b1, 0, t_a);

`ifdef UART_RX_PARITY_EN
    wait_cycles(BIT);
    send_frame(8'h31, 1'b1, 1'b1, 0, t_a);
    send_frame(8'h31, 1'b1, 1'b0, 0, t_a);
`endif

    // random traffic: good frames, low stop bits, bad parity, glitches, random gaps
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      kind = int'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        glitch(int'($urandom_range(8, 20)));
      end
      if (kind == 0) send_frame(d, 1'b0, 1'b1, int'($urandom_range(0, 3)), t_a);
      else if (kind == 1) send_frame(d, 1'b1, 1'b0, 0, t_a);
      else send_frame(d, 1'b1, 1'b1, 0, t_a);
      wait_cycles(int'($urandom_range(0, 2)) * BIT);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
